mp_adder_sched: RTL

- Multi-precision addition scheduler sharing one 64-bit adder limb (sum plus carry-out) between NUM_REQ requesters.
- Arbitrates requests round-robin and latches the winner's LIMBS-limb operands.
- Sequences the shared adder least-significant limb first, carrying the carry between cycles, then returns a (LIMBS*LIMB_W+1)-bit sum tagged with the requester id.
- Sits between crypto kernels (modular reduction, counter-mode increment) and the adder datapath.

---
 rtl/mp_adder_sched_if.sv | 21 ++
 rtl/mp_adder_sched.sv | 82 ++++++++
 2 files changed

// File: rtl/mp_adder_sched_if.sv
// mp_adder_sched_if: request/response bundle between crypto kernels and the shared adder scheduler.
interface mp_adder_sched_if #(
   parameter int LIMB_W  = 64,
   parameter int LIMBS   = 4,
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ-1:0]              req_ready;
   logic [NUM_REQ*LIMBS*LIMB_W-1:0] req_a;
   logic [NUM_REQ*LIMBS*LIMB_W-1:0] req_b;
   logic                            resp_valid;
   logic                            resp_ready;
   logic [LIMBS*LIMB_W:0]           resp_sum;
   logic [ID_W-1:0]                 resp_id;
   logic                            busy;
   modport master (output req_valid, req_a, req_b, resp_ready,
                   input  req_ready, resp_valid, resp_sum, resp_id, busy);
   modport slave  (input  req_valid, req_a, req_b, resp_ready,
                   output req_ready, resp_valid, resp_sum, resp_id, busy);
endinterface

// File: rtl/mp_adder_sched.sv
// mp_adder_sched: round-robin scheduler sharing one LIMB_W-bit adder slice for multi-limb additions,
// least-significant limb first with the carry held across cycles.
module mp_adder_sched #(
   parameter int LIMB_W  = 64,
   parameter int LIMBS   = 4,
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input logic clk,
   input logic rst,
   mp_adder_sched_if.slave bus
);
   localparam int LC_W = LIMBS > 1 ? $clog2(LIMBS) : 1;
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   state_t state;
   logic [NUM_REQ-1:0][LIMBS-1:0][LIMB_W-1:0] a_all, b_all;
   logic [LIMBS-1:0][LIMB_W-1:0] a_q, b_q, sum_q;
   logic [ID_W-1:0] rr_ptr, gnt, id_q;
   logic [LC_W-1:0] limb_cnt;
   logic carry, msb_q, valid_q, busy_q, hit, c;
   logic [LIMB_W-1:0] s;
   assign a_all = bus.req_a;
   assign b_all = bus.req_b;
   assign {c, s} = {1'b0, a_q[limb_cnt]} + {1'b0, b_q[limb_cnt]} + {{LIMB_W{1'b0}}, carry};
   // Search from the far end back so the requester nearest rr_ptr wins.
   always_comb begin
      gnt = '0;
      hit = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (bus.req_valid[(int'(rr_ptr) + i) % NUM_REQ]) begin
            gnt = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            hit = 1'b1;
         end
   end
   assign bus.req_ready  = (state == IDLE && hit) ? (NUM_REQ'(1) << gnt) : '0;
   assign bus.resp_valid = valid_q;
   assign bus.resp_sum   = {msb_q, sum_q};
   assign bus.resp_id    = id_q;
   assign bus.busy       = busy_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         limb_cnt <= '0;
         carry    <= 1'b0;
         valid_q  <= 1'b0;
         sum_q    <= '0;
         msb_q    <= 1'b0;
         id_q     <= '0;
         busy_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (hit) begin
               a_q      <= a_all[gnt];
               b_q      <= b_all[gnt];
               id_q     <= gnt;
               carry    <= 1'b0;
               limb_cnt <= '0;
               rr_ptr   <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
               busy_q   <= 1'b1;
               state    <= ADD;
            end
            ADD: begin
               sum_q[limb_cnt] <= s;
               carry           <= c;
               limb_cnt        <= limb_cnt + 1'b1;
               if (limb_cnt == LC_W'(LIMBS - 1)) begin
                  msb_q   <= c;
                  valid_q <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: if (bus.resp_ready) begin
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
